// File: rtl/jtag_tap_param.sv
// ---------------------------------------------------------------------------
// jtag_tap_param
// Parametrised IEEE 1149.1 TAP controller with a programmable IDCODE and
// NUM_USER user data registers. Each user register has a capture input and
// an update strobe. The block sits between the JTAG pins and the debug logic.
//
// Ports
//   tck               in   test clock, state advances on posedge
//   trst_n            in   asynchronous active-low TAP reset
//   tms               in   mode select, sampled on posedge tck
//   tdi               in   serial data in, sampled on posedge tck
//   tdo               out  serial data out (0 outside Shift-IR/Shift-DR)
//   tdo_en            out  1 while in Shift-IR or Shift-DR
//   tap_state         out  current TAP state (4-bit encoding below)
//   current_ir        out  active instruction
//   user_sel          out  one-hot, bit k set while user k is the instruction
//   user_capture_data in   slice k loaded at Capture-DR when user k active
//   user_update_data  out  shift contents latched at the last user Update-DR
//   user_update_valid out  one-cycle pulse on bit k after Update-DR of user k
//
// Build option
//   JTAG_TDO_NEGEDGE_EN : when defined, tdo/tdo_en are registered on the
//   falling edge of tck (IEEE output timing). When undefined they are
//   combinational from the state and the selected shift register bit 0.
// ---------------------------------------------------------------------------
module jtag_tap_param #(
   parameter int                IR_LEN       = 4,
   parameter logic [31:0]       IDCODE_VAL   = 32'h3F0F0F0F,
   parameter logic [IR_LEN-1:0] IDCODE_OP    = 4'hE,
   parameter int                NUM_USER     = 2,
   parameter logic [IR_LEN-1:0] USER_OP_BASE = 4'hC,
   parameter int                USER_DR_LEN  = 32
) (
   input  logic                            tck,
   input  logic                            trst_n,
   input  logic                            tms,
   input  logic                            tdi,
   output logic                            tdo,
   output logic                            tdo_en,
   output logic [3:0]                      tap_state,
   output logic [IR_LEN-1:0]               current_ir,
   output logic [NUM_USER-1:0]             user_sel,
   input  logic [NUM_USER*USER_DR_LEN-1:0] user_capture_data,
   output logic [USER_DR_LEN-1:0]          user_update_data,
   output logic [NUM_USER-1:0]             user_update_valid
);

   // TAP state encoding (matches the ARM7TDMI TAP numbering)
   localparam logic [3:0] ST_EX2_DR   = 4'h0;
   localparam logic [3:0] ST_EX1_DR   = 4'h1;
   localparam logic [3:0] ST_SHIFT_DR = 4'h2;
   localparam logic [3:0] ST_PAUSE_DR = 4'h3;
   localparam logic [3:0] ST_SEL_IR   = 4'h4;
   localparam logic [3:0] ST_UPD_DR   = 4'h5;
   localparam logic [3:0] ST_CAP_DR   = 4'h6;
   localparam logic [3:0] ST_SEL_DR   = 4'h7;
   localparam logic [3:0] ST_EX2_IR   = 4'h8;
   localparam logic [3:0] ST_EX1_IR   = 4'h9;
   localparam logic [3:0] ST_SHIFT_IR = 4'hA;
   localparam logic [3:0] ST_PAUSE_IR = 4'hB;
   localparam logic [3:0] ST_RTI      = 4'hC;
   localparam logic [3:0] ST_UPD_IR   = 4'hD;
   localparam logic [3:0] ST_CAP_IR   = 4'hE;
   localparam logic [3:0] ST_TLR      = 4'hF;

   localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);
   localparam logic [IR_LEN-1:0] IR_ONES    = {IR_LEN{1'b1}};

   // One-hot user decode; the all-ones opcode is always BYPASS
   function automatic logic [NUM_USER-1:0] user_decode(input logic [IR_LEN-1:0] ir);
      logic [NUM_USER-1:0] sel;
      sel = {NUM_USER{1'b0}};
      for (int k = 0; k < NUM_USER; k++) begin
         sel[k] = (ir == (USER_OP_BASE + IR_LEN'(k))) && (ir != IR_ONES);
      end
      return sel;
   endfunction

   logic [3:0]             state_r;
   logic [3:0]             next_state_s;
   logic [IR_LEN-1:0]      ir_shift_r;
   logic [IR_LEN-1:0]      current_ir_r;
   logic [IR_LEN-1:0]      ir_next_s;
   logic [NUM_USER-1:0]    user_sel_r;
   logic                   bypass_r;
   logic [31:0]            idcode_r;
   logic [USER_DR_LEN-1:0] user_dr_r;
   logic [USER_DR_LEN-1:0] user_shift_s;
   logic [USER_DR_LEN-1:0] cap_user_s;
   logic [USER_DR_LEN-1:0] user_update_data_r;
   logic [NUM_USER-1:0]    user_update_valid_r;
   logic                   sel_idcode_s;
   logic                   sel_user_s;
   logic                   tdo_s;
   logic                   tdo_en_s;

   // TAP next-state function of the current state and tms
   always_comb begin
      next_state_s = ST_TLR;
      case (state_r)
         ST_TLR:      next_state_s = tms ? ST_TLR    : ST_RTI;
         ST_RTI:      next_state_s = tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR:   next_state_s = tms ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR:   next_state_s = tms ? ST_EX1_DR : ST_SHIFT_DR;
         ST_SHIFT_DR: next_state_s = tms ? ST_EX1_DR : ST_SHIFT_DR;
         ST_EX1_DR:   next_state_s = tms ? ST_UPD_DR : ST_PAUSE_DR;
         ST_PAUSE_DR: next_state_s = tms ? ST_EX2_DR : ST_PAUSE_DR;
         ST_EX2_DR:   next_state_s = tms ? ST_UPD_DR : ST_SHIFT_DR;
         ST_UPD_DR:   next_state_s = tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR:   next_state_s = tms ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR:   next_state_s = tms ? ST_EX1_IR : ST_SHIFT_IR;
         ST_SHIFT_IR: next_state_s = tms ? ST_EX1_IR : ST_SHIFT_IR;
         ST_EX1_IR:   next_state_s = tms ? ST_UPD_IR : ST_PAUSE_IR;
         ST_PAUSE_IR: next_state_s = tms ? ST_EX2_IR : ST_PAUSE_IR;
         ST_EX2_IR:   next_state_s = tms ? ST_UPD_IR : ST_SHIFT_IR;
         ST_UPD_IR:   next_state_s = tms ? ST_SEL_DR : ST_RTI;
         default:     next_state_s = ST_TLR;
      endcase
   end

   // TAP state register
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         state_r <= ST_TLR;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next instruction: loading IDCODE on entry into TLR keeps current_ir at
   // IDCODE_OP for every cycle the TAP sits in Test-Logic-Reset.
   always_comb begin
      if (next_state_s == ST_TLR) begin
         ir_next_s = IDCODE_OP;
      end else if (state_r == ST_UPD_IR) begin
         ir_next_s = ir_shift_r;
      end else begin
         ir_next_s = current_ir_r;
      end
   end

   // Instruction shift register: capture 0..01, shift right with tdi into MSB
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         ir_shift_r <= {IR_LEN{1'b0}};
      end else begin
         case (state_r)
            ST_CAP_IR:   ir_shift_r <= IR_CAPTURE;
            ST_SHIFT_IR: ir_shift_r <= {tdi, ir_shift_r[IR_LEN-1:1]};
            default:     ir_shift_r <= ir_shift_r;
         endcase
      end
   end

   // Active instruction and its registered user decode
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         current_ir_r <= IDCODE_OP;
         user_sel_r   <= {NUM_USER{1'b0}};
      end else begin
         current_ir_r <= ir_next_s;
         user_sel_r   <= user_decode(ir_next_s);
      end
   end

   assign sel_idcode_s = (current_ir_r == IDCODE_OP) && (current_ir_r != IR_ONES);
   assign sel_user_s   = |user_sel_r;

   // Capture slice of the active user and the shifted user register value
   always_comb begin
      cap_user_s = {USER_DR_LEN{1'b0}};
      for (int k = 0; k < NUM_USER; k++) begin
         cap_user_s = cap_user_s |
            ({USER_DR_LEN{user_sel_r[k]}} & user_capture_data[k*USER_DR_LEN +: USER_DR_LEN]);
      end
      user_shift_s = user_dr_r >> 1;
      user_shift_s[USER_DR_LEN-1] = tdi;
   end

   // Data registers: capture and shift only the register selected by the IR
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         bypass_r  <= 1'b0;
         idcode_r  <= 32'd0;
         user_dr_r <= {USER_DR_LEN{1'b0}};
      end else begin
         case (state_r)
            ST_CAP_DR: begin
               bypass_r <= 1'b0;
               if (sel_idcode_s) begin
                  idcode_r <= IDCODE_VAL;
               end else if (sel_user_s) begin
                  user_dr_r <= cap_user_s;
               end else begin
                  idcode_r <= idcode_r;
               end
            end
            ST_SHIFT_DR: begin
               if (sel_idcode_s) begin
                  idcode_r <= {tdi, idcode_r[31:1]};
               end else if (sel_user_s) begin
                  user_dr_r <= user_shift_s;
               end else begin
                  bypass_r <= tdi;
               end
            end
            default: begin
               bypass_r <= bypass_r;
            end
         endcase
      end
   end

   // User update: latch data and pulse the active user bit for one cycle
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         user_update_data_r  <= {USER_DR_LEN{1'b0}};
         user_update_valid_r <= {NUM_USER{1'b0}};
      end else if ((state_r == ST_UPD_DR) && sel_user_s) begin
         user_update_data_r  <= user_dr_r;
         user_update_valid_r <= user_sel_r;
      end else begin
         user_update_valid_r <= {NUM_USER{1'b0}};
      end
   end

   // Serial output source: IR bit 0 in Shift-IR, selected DR bit 0 in Shift-DR
   always_comb begin
      tdo_s    = 1'b0;
      tdo_en_s = 1'b0;
      case (state_r)
         ST_SHIFT_IR: begin
            tdo_s    = ir_shift_r[0];
            tdo_en_s = 1'b1;
         end
         ST_SHIFT_DR: begin
            tdo_en_s = 1'b1;
            if (sel_idcode_s) begin
               tdo_s = idcode_r[0];
            end else if (sel_user_s) begin
               tdo_s = user_dr_r[0];
            end else begin
               tdo_s = bypass_r;
            end
         end
         default: begin
            tdo_s    = 1'b0;
            tdo_en_s = 1'b0;
         end
      endcase
   end

`ifdef JTAG_TDO_NEGEDGE_EN
   logic tdo_r;
   logic tdo_en_r;

   // Falling-edge output register so tdo changes half a cycle after the shift
   always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n) begin
         tdo_r    <= 1'b0;
         tdo_en_r <= 1'b0;
      end else begin
         tdo_r    <= tdo_s;
         tdo_en_r <= tdo_en_s;
      end
   end

   assign tdo    = tdo_r;
   assign tdo_en = tdo_en_r;
`else
   assign tdo    = tdo_s;
   assign tdo_en = tdo_en_s;
`endif

   assign tap_state         = state_r;
   assign current_ir        = current_ir_r;
   assign user_sel          = user_sel_r;
   assign user_update_data  = user_update_data_r;
   assign user_update_valid = user_update_valid_r;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param. Inputs change and outputs are sampled
// 1 ns after the falling edge of tck, which is valid for both tdo timing
// options. Expected serial streams and update data go through a scoreboard
// queue: pushed when the stimulus is issued, popped when the DUT output has
// been collected.
module tb_jtag_tap_param;

   logic        tck;
   logic        trst_n;
   logic        tms;
   logic        tdi;
   logic        tdo;
   logic        tdo_en;
   logic [3:0]  tap_state;
   logic [3:0]  current_ir;
   logic [1:0]  user_sel;
   logic [63:0] user_capture_data;
   logic [31:0] user_update_data;
   logic [1:0]  user_update_valid;

   int   checks;
   int   failures;
   logic sampled_tdo;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];

   jtag_tap_param dut (
      .tck               (tck),
      .trst_n            (trst_n),
      .tms               (tms),
      .tdi               (tdi),
      .tdo               (tdo),
      .tdo_en            (tdo_en),
      .tap_state         (tap_state),
      .current_ir        (current_ir),
      .user_sel          (user_sel),
      .user_capture_data (user_capture_data),
      .user_update_data  (user_update_data),
      .user_update_valid (user_update_valid)
   );

   initial begin
      tck = 1'b0;
      forever #5 tck = ~tck;
   end

   // Watchdog: the directed sequence is a few hundred cycles
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   // One tck cycle: sample tdo for the current state, then drive and clock
   task automatic tick(input logic tms_v, input logic tdi_v);
      sampled_tdo = tdo;
      tms = tms_v;
      tdi = tdi_v;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   // RTI -> Shift-IR, shift n bits, -> Update-IR -> RTI
   task automatic shift_ir(input int n, input logic [31:0] din, output logic [31:0] dout);
      dout = 32'd0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("shift_ir_state", {28'd0, tap_state}, 32'h0000000A);
      for (int i = 0; i < n; i++) begin
         tick((i == n - 1) ? 1'b1 : 1'b0, din[i]);
         dout[i] = sampled_tdo;
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   // RTI -> Shift-DR, shift n bits, -> Exit1-DR -> Update-DR (stays there)
   task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
      dout = 32'd0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("shift_dr_en", {31'd0, tdo_en}, 32'd1);
      for (int i = 0; i < n; i++) begin
         tick((i == n - 1) ? 1'b1 : 1'b0, din[i]);
         dout[i] = sampled_tdo;
      end
      tick(1'b1, 1'b0);
      check("upd_dr_state", {28'd0, tap_state}, 32'h00000005);
      check("upd_dr_tdo_idle", {30'd0, tdo_en, tdo}, 32'd0);
   endtask

   initial begin
      logic [31:0] out;
      checks   = 0;
      failures = 0;
      trst_n = 1'b0;
      tms    = 1'b1;
      tdi    = 1'b0;
      user_capture_data = {32'h12345678, 32'hA5A50001};

      // Reset values
      repeat (2) @(negedge tck);
      #1;
      check("rst_state", {28'd0, tap_state}, 32'h0000000F);
      check("rst_ir", {28'd0, current_ir}, 32'h0000000E);
      check("rst_user_sel", {30'd0, user_sel}, 32'd0);
      check("rst_upd", {user_update_data}, 32'd0);
      check("rst_valid_tdo", {28'd0, user_update_valid, tdo_en, tdo}, 32'd0);
      trst_n = 1'b1;

      // 1: six tms=1 stays in TLR, then RTI and read IDCODE
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
      check("tlr_state", {28'd0, tap_state}, 32'h0000000F);
      tick(1'b0, 1'b0);
      check("rti_state", {28'd0, tap_state}, 32'h0000000C);
      sb_push("idcode_stream", 32'h3F0F0F0F);
      shift_dr(32, 32'd0, out);
      sb_pop(out);
      tick(1'b0, 1'b0);
      check("idcode_ir", {28'd0, current_ir}, 32'h0000000E);
      check("idcode_no_pulse", {30'd0, user_update_valid}, 32'd0);

      // 2: load USER0, captured IR pattern is 0001
      sb_push("ir_capture", 32'h00000001);
      shift_ir(4, 32'h0000000C, out);
      sb_pop(out);
      check("ir_user0", {28'd0, current_ir}, 32'h0000000C);
      check("sel_user0", {30'd0, user_sel}, 32'h00000001);

      // 3: USER0 capture/shift/update with a single-cycle pulse
      sb_push("user0_capture", 32'hA5A50001);
      shift_dr(32, 32'hDEADBEEF, out);
      sb_pop(out);
      check("user0_pre_pulse", {30'd0, user_update_valid}, 32'd0);
      sb_push("user0_update", 32'hDEADBEEF);
      tick(1'b0, 1'b0);
      check("user0_pulse", {30'd0, user_update_valid}, 32'h00000001);
      sb_pop(user_update_data);
      tick(1'b0, 1'b0);
      check("user0_pulse_end", {30'd0, user_update_valid}, 32'd0);
      check("user0_hold", user_update_data, 32'hDEADBEEF);

      // 3b: USER1 update straight from Capture-DR with zero shift cycles
      shift_ir(4, 32'h0000000D, out);
      check("sel_user1", {30'd0, user_sel}, 32'h00000002);
      check("user1_ir_keeps_data", user_update_data, 32'hDEADBEEF);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      sb_push("user1_zero_shift", 32'h12345678);
      tick(1'b0, 1'b0);
      check("user1_pulse", {30'd0, user_update_valid}, 32'h00000002);
      sb_pop(user_update_data);

      // 4: BYPASS via all-ones and via an undefined opcode
      for (int r = 0; r < 2; r++) begin
         shift_ir(4, (r == 0) ? 32'h0000000F : 32'h00000005, out);
         check("byp_ir", {28'd0, current_ir}, (r == 0) ? 32'h0000000F : 32'h00000005);
         check("byp_sel", {30'd0, user_sel}, 32'd0);
         sb_push("byp_stream", 32'h0000000A);
         shift_dr(4, 32'h0000000D, out);
         sb_pop(out);
         tick(1'b0, 1'b0);
         check("byp_no_pulse", {30'd0, user_update_valid}, 32'd0);
         check("byp_data_kept", user_update_data, 32'h12345678);
      end

      // 5a: five tms=1 from the middle of a USER1 shift reaches TLR
      shift_ir(4, 32'h0000000D, out);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0, i[0]);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      check("tms5_state", {28'd0, tap_state}, 32'h0000000F);
      check("tms5_ir", {28'd0, current_ir}, 32'h0000000E);
      check("tms5_no_pulse", {28'd0, user_sel, user_update_valid}, 32'd0);
      tick(1'b0, 1'b0);

      // 5b: asynchronous trst_n in the middle of a USER1 shift
      shift_ir(4, 32'h0000000D, out);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
      #1 trst_n = 1'b0;
      #1;
      check("trst_state", {28'd0, tap_state}, 32'h0000000F);
      check("trst_ir", {28'd0, current_ir}, 32'h0000000E);
      check("trst_outs", {26'd0, user_sel, user_update_valid, tdo_en, tdo}, 32'd0);
      check("trst_data", user_update_data, 32'd0);
      @(negedge tck);
      #1 trst_n = 1'b1;
      tick(1'b0, 1'b0);
      check("post_trst_rti", {28'd0, tap_state}, 32'h0000000C);

      check("sb_drain", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
